// File: rtl/coin_acceptor_if.sv
// Coin acceptor bus: raw sensors and lock in, coin code and status out.
// sel and reject are one-cycle pulses with no back-pressure; a nonzero sel or a high reject is the "valid" and there is no ready.
interface coin_acceptor_if;
   logic [2:0] coin_in;
   logic       lock;
   logic [1:0] sel;
   logic       reject;
   logic       jam;
   logic       busy;
   logic [1:0] dbg_state;

   modport master (
      output coin_in, lock,
      input  sel, reject, jam, busy, dbg_state
   );

   modport slave (
      input  coin_in, lock,
      output sel, reject, jam, busy, dbg_state
   );
endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronize, debounce and validate three coin sensors into a one-cycle coin code.
// Optional jam timer is enabled by defining COIN_ACC_TIMEOUT_EN.
module coin_acceptor #(
   parameter int DEB_CYC     = 4,
   parameter int TIMEOUT_CYC = 1000,
   parameter int CNT_W       = 10
) (
   input  logic           clk,
   input  logic           rst,
   coin_acceptor_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      DEBOUNCE     = 2'd1,
      REJECT       = 2'd2,
      WAIT_RELEASE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);

   if (DEB_CYC < 2 || DEB_CYC > (2**CNT_W) - 1) begin : g_bad_deb
      $error("coin_acceptor: DEB_CYC out of range");
   end
   if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > (2**CNT_W) - 1) begin : g_bad_to
      $error("coin_acceptor: TIMEOUT_CYC does not fit CNT_W");
   end

   logic [2:0]       sync1_q, sync2_q;
   logic [2:0]       s;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       pat_q, pat_d;
   logic [1:0]       sel_q, sel_d;
   logic             rej_q, rej_d;
   logic             busy_q;
   logic             one_hot;
   logic [1:0]       pat_code;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 3'b000;
         sync2_q <= 3'b000;
      end else begin
         sync1_q <= bus.coin_in;
         sync2_q <= sync1_q;
      end
   end

   assign s       = sync2_q;
   assign one_hot = (s != 3'b000) && ((s & 3'(s - 3'd1)) == 3'b000);

   always_comb begin
      pat_code = 2'b00;
      case (pat_q)
         3'b001:  pat_code = 2'b01;
         3'b010:  pat_code = 2'b10;
         3'b100:  pat_code = 2'b11;
         default: pat_code = 2'b00;
      endcase
   end

`ifdef COIN_ACC_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYC);

   logic [CNT_W-1:0] timer_q, timer_d;
   logic             jam_q, jam_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pat_d   = pat_q;
      sel_d   = 2'b00;
      rej_d   = 1'b0;
`ifdef COIN_ACC_TIMEOUT_EN
      timer_d = timer_q;
      jam_d   = jam_q;
`endif

      case (state_q)
         IDLE: begin
            if (s != 3'b000) begin
               if (one_hot) begin
                  pat_d   = s;
                  cnt_d   = CNT_W'(1);
                  state_d = DEBOUNCE;
               end else begin
                  state_d = REJECT;
               end
            end
         end
         DEBOUNCE: begin
            if (s == 3'b000) begin
               state_d = IDLE;
            end else if (s != pat_q) begin
               state_d = REJECT;
            end else if (cnt_q == DEB_LAST) begin
               // lock only matters on the accepting edge
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = WAIT_RELEASE;
               if (bus.lock) begin
                  rej_d = 1'b1;
               end else begin
                  sel_d = pat_code;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         REJECT: begin
            rej_d   = 1'b1;
            state_d = WAIT_RELEASE;
         end
         WAIT_RELEASE: begin
            if (s == 3'b000) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

`ifdef COIN_ACC_TIMEOUT_EN
      if (state_q == IDLE) begin
         timer_d = '0;
      end else if (timer_q != TO_VAL) begin
         timer_d = timer_q + CNT_W'(1);
      end

      // a release back to IDLE wins over a timeout on the same edge
      if (state_q != IDLE && timer_d == TO_VAL && state_d != IDLE) begin
         jam_d   = 1'b1;
         state_d = WAIT_RELEASE;
         if (state_q == DEBOUNCE) begin
            sel_d = 2'b00;
            rej_d = 1'b0;
         end
      end

      if (state_d == IDLE) begin
         jam_d = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pat_q   <= 3'b000;
         sel_q   <= 2'b00;
         rej_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pat_q   <= pat_d;
         sel_q   <= sel_d;
         rej_q   <= rej_d;
         busy_q  <= (state_d != IDLE);
      end
   end

`ifdef COIN_ACC_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         timer_q <= '0;
         jam_q   <= 1'b0;
      end else begin
         timer_q <= timer_d;
         jam_q   <= jam_d;
      end
   end

   assign bus.jam = jam_q;
`else
   assign bus.jam = 1'b0;
`endif

   assign bus.sel       = sel_q;
   assign bus.reject    = rej_q;
   assign bus.busy      = busy_q;
   assign bus.dbg_state = state_q;

endmodule
